// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared widths and helpers for the FIFO read-side stream engine
//   FE_DATA_W    : front-end word width (matches the FIFO data width)
//   FE_BURST_LEN : default number of beats per output burst
//   cnt_w()      : width of a counter spanning 0..n-1 (at least 1 bit)
package fifo_stream_reader_pkg;
   localparam int FE_DATA_W    = 8;
   localparam int FE_BURST_LEN = 8;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready output stream with burst framing
//   fifo_empty, fifo_data : from FIFO (empty flag, registered data_out)
//   fifo_r_en             : to FIFO (read enable)
//   m_valid, m_data, m_last : stream towards the datapath
//   m_ready               : stream accept from the datapath
//   master modport = the reader engine, slave modport = FIFO + downstream side
interface fifo_stream_reader_if
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_W = FE_DATA_W
);
   logic              fifo_empty;
   logic              fifo_r_en;
   logic [DATA_W-1:0] fifo_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_r_en, m_valid, m_data, m_last
   );
   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_r_en, m_valid, m_data, m_last
   );
endinterface

// File: rtl/fifo_stream_reader_skid_buf3.sv
// skid_buf3: 3-entry circular buffer with occupancy, push/pop and synchronous clear
//   clk, rst_n : clock, asynchronous active-low reset (clears contents too)
//   clr        : synchronous clear of pointers and occupancy (takes priority)
//   push, din  : write din at the tail
//   pop        : advance the head; caller guarantees occ != 0
//   dout, occ  : head word, number of stored words (0..3)
module skid_buf3 #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [1:0]        occ
);
   localparam int DEPTH = 3;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [1:0]        wr_ptr, rd_ptr;
   // pointers wrap modulo 3, not at the natural 2-bit boundary
   function automatic logic [1:0] inc(input logic [1:0] p);
      return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         occ    <= 2'd0;
      end else if (clr) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         occ    <= 2'd0;
      end else begin
         if (push) mem[wr_ptr] <= din;
         wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
         rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
         occ    <= occ + {1'b0, push} - {1'b0, pop};
      end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-output FIFO into a valid/ready stream with burst framing
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous drop of buffered and in-flight words, restarts the burst
//   idle       : nothing buffered and nothing in flight
//   bus        : FIFO read port and output stream (master modport)
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_W    = FE_DATA_W,
   parameter int BURST_LEN = FE_BURST_LEN
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   output logic                idle,
   fifo_stream_reader_if.master bus
);
   localparam int SKID_DEPTH = 3;
   localparam int BW         = cnt_w(BURST_LEN);
   logic              inflight, hs;
   logic [1:0]        occ;
   logic [BW-1:0]     beat_cnt;
   logic [DATA_W-1:0] dout;
   // issue only when the word already requested still has a free slot waiting for it;
   // uses registered state only, so m_ready never reaches fifo_r_en combinationally
   assign bus.fifo_r_en = rst_n & ~flush & ~bus.fifo_empty &
                          (({1'b0, occ} + {2'b0, inflight}) < 3'(SKID_DEPTH));
   assign bus.m_valid   = (occ != 2'd0);
   assign bus.m_data    = dout;
   assign bus.m_last    = bus.m_valid & (beat_cnt == BW'(BURST_LEN - 1));
   assign hs            = bus.m_valid & bus.m_ready & ~flush;
   assign idle          = (occ == 2'd0) & ~inflight;
   skid_buf3 #(.DATA_W(DATA_W)) u_skid (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (flush),
      .push (inflight & ~flush),
      .pop  (hs),
      .din  (bus.fifo_data),
      .dout (dout),
      .occ  (occ)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         inflight <= 1'b0;
         beat_cnt <= '0;
      end else if (flush) begin
         inflight <= 1'b0;
         beat_cnt <= '0;
      end else begin
         inflight <= bus.fifo_r_en;
         if (hs) beat_cnt <= bus.m_last ? '0 : beat_cnt + BW'(1);
      end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench with a behavioural FIFO, random backpressure and a BURST_LEN=1 instance
module tb_fifo_stream_reader;
   import fifo_stream_reader_pkg::*;
   localparam int BL = 8;
   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic idle, idle1;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] mem [1024];
   int   wr_idx = 0;
   int   rd_idx = 0;
   int   ex_idx = 0;
   int   beat   = 0;
   logic       have_prev = 1'b0;
   logic [7:0] prev_data = '0;
   int   pop1 = 0;
   int   beats1 = 0;
   always #5 clk = ~clk;
   fifo_stream_reader_if #(.DATA_W(8)) bus ();
   fifo_stream_reader_if #(.DATA_W(8)) b1 ();
   fifo_stream_reader #(.DATA_W(8), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .idle(idle), .bus(bus)
   );
   fifo_stream_reader #(.DATA_W(8), .BURST_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .idle(idle1), .bus(b1)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [7:0] d);
      mem[wr_idx] = d;
      wr_idx++;
   endtask
   task automatic drain(input string nm, input bit rnd);
      int n;
      n = 0;
      while (!(idle && rd_idx == wr_idx && ex_idx == wr_idx) && n < 600) begin
         if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      chk({nm, "_bounded"}, 32'(n < 600), 32'd1);
      chk({nm, "_all_out"}, 32'(ex_idx), 32'(wr_idx));
   endtask
   // behavioural FIFO: registered data_out, one word per r_en
   assign bus.fifo_empty = (rd_idx == wr_idx);
   always @(posedge clk)
      if (bus.fifo_r_en) begin
         bus.fifo_data <= mem[rd_idx];
         rd_idx <= rd_idx + 1;
      end
   // scoreboard monitor: output order must equal push order; words still in the FIFO
   // at a flush/reset are the only ones that survive it
   always @(negedge clk)
      if (!rst_n || flush) begin
         ex_idx    = rd_idx;
         beat      = 0;
         have_prev = 1'b0;
      end else begin
         if (have_prev) chk("hold_data", 32'(bus.m_data), 32'(prev_data));
         if (bus.m_valid && bus.m_ready) begin
            if (ex_idx >= wr_idx) chk("extra_word", 32'(bus.m_data), 32'hdead);
            else begin
               chk("data", 32'(bus.m_data), 32'(mem[ex_idx]));
               chk("last", 32'(bus.m_last), 32'((beat % BL) == BL - 1));
               ex_idx++;
               beat++;
            end
         end
         have_prev = bus.m_valid && !bus.m_ready;
         prev_data = bus.m_data;
      end
   // BURST_LEN=1 instance: 12 counting words, every beat is last
   assign b1.fifo_empty = (pop1 == 12);
   assign b1.m_ready    = 1'b1;
   always @(posedge clk)
      if (b1.fifo_r_en) begin
         b1.fifo_data <= 8'(pop1 + 1);
         pop1 <= pop1 + 1;
      end
   always @(negedge clk)
      if (rst_n && b1.m_valid) begin
         chk("bl1_last", 32'(b1.m_last), 32'd1);
         chk("bl1_data", 32'(b1.m_data), 32'(beats1 + 1));
         beats1++;
      end
   initial begin
      int pops, n, fbase;
      rst_n = 1'b0;
      flush = 1'b0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_r_en", 32'(bus.fifo_r_en), 32'd0);
      chk("rst_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_last", 32'(bus.m_last), 32'd0);
      chk("rst_data", 32'(bus.m_data), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      tick();
      rst_n = 1'b1;
      // streaming: 16 words, 2-cycle latency, then one per cycle
      bus.m_ready = 1'b1;
      for (int i = 1; i <= 16; i++) push(8'(i));
      @(negedge clk);
      chk("str_r_en", 32'(bus.fifo_r_en), 32'd1);
      chk("str_lat0", 32'(bus.m_valid), 32'd0);
      @(negedge clk);
      chk("str_lat1", 32'(bus.m_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("str_contig", 32'(bus.m_valid), 32'd1);
      end
      @(negedge clk);
      chk("str_end", 32'(bus.m_valid), 32'd0);
      @(negedge clk);
      chk("str_idle", 32'(idle), 32'd1);
      // stall: only 3 pops while blocked, head word held
      tick();
      bus.m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push(8'(i));
      pops = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pops += 32'(bus.fifo_r_en);
      end
      chk("stall_pops", 32'(pops), 32'd3);
      chk("stall_r_en", 32'(bus.fifo_r_en), 32'd0);
      chk("stall_data", 32'(bus.m_data), 32'd1);
      tick();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_release", 32'(bus.m_valid), 32'd1);
      end
      tick();
      drain("stall", 1'b0);
      // random backpressure with a concurrent writer
      n = 0;
      while (n < 200) begin
         bus.m_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0) begin
            push(8'($urandom));
            n++;
         end
         tick();
      end
      drain("random", 1'b1);
      // flush with occ=2, inflight=1
      bus.m_ready = 1'b0;
      fbase = wr_idx;
      for (int i = 0; i < 10; i++) push(8'($urandom));
      tick();
      tick();
      tick();
      chk("pre_flush_r_en", 32'(bus.fifo_r_en), 32'd0);
      chk("pre_flush_idle", 32'(idle), 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_valid", 32'(bus.m_valid), 32'd0);
      chk("flush_idle", 32'(idle), 32'd1);
      bus.m_ready = 1'b1;
      n = 0;
      while (!bus.m_valid && n < 10) begin
         tick();
         n++;
      end
      chk("flush_first", 32'(bus.m_data), 32'(mem[fbase + 3]));
      chk("flush_beat0", 32'(bus.m_last), 32'd0);
      drain("flush", 1'b0);
      // mid-stream asynchronous reset
      for (int i = 0; i < 20; i++) push(8'($urandom));
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_r_en", 32'(bus.fifo_r_en), 32'd0);
      chk("mrst_valid", 32'(bus.m_valid), 32'd0);
      chk("mrst_last", 32'(bus.m_last), 32'd0);
      chk("mrst_data", 32'(bus.m_data), 32'd0);
      chk("mrst_idle", 32'(idle), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("mrst_hold_r_en", 32'(bus.fifo_r_en), 32'd0);
      end
      tick();
      rst_n = 1'b1;
      drain("mrst", 1'b0);
      chk("bl1_beats", 32'(beats1), 32'd12);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
